// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART transmit-side arbitration logic.
package uart_alu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

    localparam int ARB_NUM_CH = 2;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the uart_tx byte stream between the
// ALU FSM result source (ch0) and the debug/status source (ch1).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no grant, outputs quiet; picks next channel from requests
// ARB_GRANT0 | ch0 owns the stream until its last byte or the watchdog
// ARB_GRANT1 | ch1 owns the stream until its last byte or the watchdog
module uart_tx_arbiter
    import uart_alu_pkg::*;
#(
    parameter int WIDTH_P   = 8,
    parameter int MAX_PKT_P = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ARB_NUM_CH*WIDTH_P-1:0]   req_data_i,
    input  logic [ARB_NUM_CH-1:0]           req_valid_i,
    input  logic [ARB_NUM_CH-1:0]           req_last_i,
    output logic [ARB_NUM_CH-1:0]           req_ready_o,
    output logic [WIDTH_P-1:0]              data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [ARB_NUM_CH-1:0]           grant_o,
    output logic                            abort_o
);

    localparam int              CNT_W    = $clog2(MAX_PKT_P) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_P - 1);

    arb_state_e       r_state;
    logic             r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;

    arb_state_e       w_state_nxt;
    logic             w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_abort_nxt;
    logic             w_sel;
    logic             w_ch;
    logic             w_hs;

    // Index of the channel currently holding the grant and its handshake.
    // The handshake is built from the raw inputs so valid_o never sees ready_i.
    assign w_ch = (r_state == ARB_GRANT1);
    assign w_hs = (r_state != ARB_IDLE) & req_valid_i[w_ch] & ready_i;

    // State, round-robin pointer, beat counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // Next-state: arbitration in IDLE, packet tracking and watchdog while granted.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = 1'b0;
        w_sel       = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (|req_valid_i) begin
                    w_sel       = req_valid_i[r_ptr] ? r_ptr : ~r_ptr;
                    w_state_nxt = w_sel ? ARB_GRANT1 : ARB_GRANT0;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (w_hs) begin
                    if (req_last_i[w_ch] || (r_cnt == CNT_LAST)) begin
                        // Release: the other channel gets priority next time.
                        w_state_nxt = ARB_IDLE;
                        w_ptr_nxt   = ~w_ch;
                        w_cnt_nxt   = '0;
                        w_abort_nxt = ~req_last_i[w_ch];
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output mux: granted channel passes straight through, everything quiet in IDLE.
    always_comb begin
        grant_o     = '0;
        data_o      = '0;
        valid_o     = 1'b0;
        req_ready_o = '0;
        case (r_state)
            ARB_GRANT0: begin
                grant_o        = 2'b01;
                data_o         = req_data_i[0 +: WIDTH_P];
                valid_o        = req_valid_i[0];
                req_ready_o[0] = ready_i;
            end
            ARB_GRANT1: begin
                grant_o        = 2'b10;
                data_o         = req_data_i[WIDTH_P +: WIDTH_P];
                valid_o        = req_valid_i[1];
                req_ready_o[1] = ready_i;
            end
            default: begin
                grant_o = '0;
            end
        endcase
    end

    assign abort_o = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a cycle vector table for reset, single packets,
// pointer hand-off and backpressure, then queue-driven sequences for
// alternation, watchdog release and reset in the middle of a packet.
module tb_uart_tx_arbiter;

    localparam int MAX = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [1:0]  grant;
    logic        abort;

    uart_tx_arbiter #(.WIDTH_P(8), .MAX_PKT_P(MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .grant_o     (grant),
        .abort_o     (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [1:0] l;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] eg;
        logic       ev;
        logic [1:0] er;
        logic [7:0] ed;
        logic       ea;
    } vec_t;

    vec_t vecs [17];

    int checks = 0;
    int errors = 0;

    // source model: {last, byte} per channel; expected wire order in exp_q
    logic [8:0] src0 [$];
    logic [8:0] src1 [$];
    logic [9:0] exp_q [$];
    logic [1:0] en;
    int         beats;
    logic       exp_abort;
    int         n_pop1;
    int         aborts_seen;

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] l,
                                input logic [7:0] d0, input logic [7:0] d1, input logic rdy,
                                input logic [1:0] eg, input logic ev, input logic [1:0] er,
                                input logic [7:0] ed, input logic ea);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.eg = eg; t.ev = ev; t.er = er; t.ed = ed; t.ea = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_update();
        req_valid[0]   = en[0] && (src0.size() > 0);
        req_valid[1]   = en[1] && (src1.size() > 0);
        req_data[7:0]  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
        req_data[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
        req_last[0]    = (src0.size() > 0) ? src0[0][8] : 1'b0;
        req_last[1]    = (src1.size() > 0) ? src1[0][8] : 1'b0;
    endtask

    task automatic push_src(input int ch, input logic [7:0] b, input logic lst);
        if (ch == 0) src0.push_back({lst, b});
        else         src1.push_back({lst, b});
    endtask

    task automatic push_exp(input int ch, input logic [7:0] b);
        logic [1:0] oh;
        oh = (ch == 0) ? 2'b01 : 2'b10;
        exp_q.push_back({oh, b});
    endtask

    task automatic push_pkt(input int ch, input logic [7:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            push_src(ch, base + 8'(i), with_last && (i == n - 1));
            push_exp(ch, base + 8'(i));
        end
    endtask

    // one clock: monitor at negedge, then update sources after the edge
    task automatic step();
        logic       hs0, hs1, lst;
        logic [9:0] e;
        @(negedge clk);
        chk("abort_pulse", 16'(abort), 16'(exp_abort));
        if (abort) aborts_seen++;
        chk("ready_only_granted", 16'(req_ready & ~grant), 16'h0);
        hs0 = req_valid[0] & req_ready[0];
        hs1 = req_valid[1] & req_ready[1];
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h grant %0b, expected none", data, grant);
            end else begin
                e = exp_q.pop_front();
                chk("byte_grant_data", 16'({grant, data}), 16'(e));
            end
        end
        exp_abort = 1'b0;
        if (hs0 || hs1) begin
            lst = hs0 ? req_last[0] : req_last[1];
            if (lst || beats == MAX - 1) begin
                exp_abort = !lst;
                beats     = 0;
            end else begin
                beats++;
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            beats     = 0;
            exp_abort = 1'b0;
        end
        if (hs0) void'(src0.pop_front());
        if (hs1) begin
            void'(src1.pop_front());
            n_pop1++;
        end
        drive_update();
    endtask

    task automatic reset_dut();
        src0.delete();
        src1.delete();
        exp_q.delete();
        en          = 2'b00;
        ready       = 1'b1;
        rst         = 1'b0;
        n_pop1      = 0;
        aborts_seen = 0;
        drive_update();
        repeat (3) step();
        rst = 1'b1;
        drive_update();
    endtask

    task automatic run_seq(input string name, input int budget, input bit rnd_rdy, input int en0_at);
        int c;
        c = 0;
        while (c < budget && !(exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0)) begin
            if (c == en0_at) begin
                en[0] = 1'b1;
                drive_update();
            end
            ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            c++;
        end
        ready = 1'b1;
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes outstanding, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(0, 2'b11, 2'b00, 8'h12, 8'h55, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[1]  = mk(0, 2'b11, 2'b00, 8'h12, 8'h55, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[2]  = mk(0, 2'b11, 2'b00, 8'h12, 8'h55, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[3]  = mk(1, 2'b01, 2'b00, 8'h12, 8'h55, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[4]  = mk(1, 2'b01, 2'b00, 8'h12, 8'h55, 1, 2'b01, 1, 2'b01, 8'h12, 0);
        vecs[5]  = mk(1, 2'b01, 2'b01, 8'h34, 8'h55, 1, 2'b01, 1, 2'b01, 8'h34, 0);
        vecs[6]  = mk(1, 2'b11, 2'b00, 8'h56, 8'h78, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[7]  = mk(1, 2'b11, 2'b00, 8'h56, 8'h78, 1, 2'b10, 1, 2'b10, 8'h78, 0);
        vecs[8]  = mk(1, 2'b11, 2'b00, 8'h56, 8'h9A, 0, 2'b10, 1, 2'b00, 8'h9A, 0);
        vecs[9]  = mk(1, 2'b11, 2'b00, 8'h56, 8'h9A, 0, 2'b10, 1, 2'b00, 8'h9A, 0);
        vecs[10] = mk(1, 2'b11, 2'b00, 8'h56, 8'h9A, 0, 2'b10, 1, 2'b00, 8'h9A, 0);
        vecs[11] = mk(1, 2'b11, 2'b00, 8'h56, 8'h9A, 0, 2'b10, 1, 2'b00, 8'h9A, 0);
        vecs[12] = mk(1, 2'b11, 2'b10, 8'h56, 8'h9A, 1, 2'b10, 1, 2'b10, 8'h9A, 0);
        vecs[13] = mk(1, 2'b10, 2'b00, 8'h56, 8'hBC, 1, 2'b00, 0, 2'b00, 8'h00, 0);
        vecs[14] = mk(1, 2'b00, 2'b00, 8'h56, 8'hBC, 1, 2'b10, 0, 2'b10, 8'hBC, 0);
        vecs[15] = mk(1, 2'b10, 2'b10, 8'h56, 8'hBC, 1, 2'b10, 1, 2'b10, 8'hBC, 0);
        vecs[16] = mk(1, 2'b00, 2'b00, 8'h56, 8'hBC, 1, 2'b00, 0, 2'b00, 8'h00, 0);

        en        = 2'b00;
        beats     = 0;
        exp_abort = 1'b0;
        rst       = 1'b0;
        req_valid = 2'b11;
        req_last  = 2'b00;
        req_data  = 16'h5512;
        ready     = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            rst       = vecs[i].rst;
            req_valid = vecs[i].v;
            req_last  = vecs[i].l;
            req_data  = {vecs[i].d1, vecs[i].d0};
            ready     = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_grant", i), 16'(grant), 16'(vecs[i].eg));
            chk($sformatf("v%0d_valid", i), 16'(valid), 16'(vecs[i].ev));
            chk($sformatf("v%0d_ready", i), 16'(req_ready), 16'(vecs[i].er));
            chk($sformatf("v%0d_data", i), 16'(data), 16'(vecs[i].ed));
            chk($sformatf("v%0d_abort", i), 16'(abort), 16'(vecs[i].ea));
            @(posedge clk);
            #1;
        end

        // alternation under continuous load with random backpressure
        reset_dut();
        chk("reset_grant", 16'(grant), 16'h0);
        push_pkt(0, 8'h10, 3, 1);
        push_pkt(1, 8'h20, 3, 1);
        push_pkt(0, 8'h13, 3, 1);
        push_pkt(1, 8'h23, 3, 1);
        en = 2'b11;
        drive_update();
        run_seq("alternate", 200, 1, -1);
        chk("alternate_no_abort", 16'(aborts_seen), 16'h0);

        // watchdog: ch1 never flags last, ch0 joins later
        reset_dut();
        push_pkt(1, 8'h40, MAX, 0);
        push_pkt(0, 8'hC0, 1, 1);
        en = 2'b10;
        drive_update();
        run_seq("watchdog", 200, 0, 3);
        chk("watchdog_abort_count", 16'(aborts_seen), 16'h1);

        // reset after 2 of 5 bytes of a ch1 packet
        reset_dut();
        push_src(1, 8'h60, 0); push_src(1, 8'h61, 0); push_src(1, 8'h62, 0);
        push_src(1, 8'h63, 0); push_src(1, 8'h64, 1);
        push_src(0, 8'h70, 1);
        push_exp(1, 8'h60); push_exp(1, 8'h61); push_exp(0, 8'h70);
        push_exp(1, 8'h62); push_exp(1, 8'h63); push_exp(1, 8'h64);
        en = 2'b10;
        drive_update();
        for (int c = 0; c < 50 && n_pop1 < 2; c++) step();
        chk("rst_mid_two_sent", 16'(n_pop1), 16'h2);
        ready = 1'b0;
        rst   = 1'b0;
        en[0] = 1'b1;
        drive_update();
        step();
        rst   = 1'b1;
        ready = 1'b1;
        drive_update();
        @(negedge clk);
        chk("rst_mid_idle_grant", 16'(grant), 16'h0);
        chk("rst_mid_idle_valid", 16'(valid), 16'h0);
        @(posedge clk);
        #1;
        run_seq("rst_mid", 100, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
